// File: rtl/lcd_bus_engine_pkg.sv
// Shared types and helpers for the HD44780-style LCD bus engine.
// Holds the FSM state encoding, the latched command layout and the us-to-cycle conversion.
package lcd_pkg;

    localparam int LCD_DELAY_MAX_W = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_E_HIGH,
        ST_HOLD,
        ST_DELAY,
        ST_DONE
    } lcd_state_t;

    typedef struct packed {
        logic [7:0]                 data;
        logic                       rs;
        logic                       read;
        logic                       poll;
        logic [LCD_DELAY_MAX_W-1:0] delay;
    } lcd_cmd_t;

    // Never returns 0 so every bus phase lasts at least one clock.
    function automatic logic [31:0] us_to_cycles(input logic [63:0] freq, input logic [31:0] us);
        logic [63:0] cyc;
        cyc = (freq / 64'd1_000_000) * 64'(us);
        return (cyc == 64'd0) ? 32'd1 : cyc[31:0];
    endfunction

endpackage

// File: rtl/lcd_bus_engine_if.sv
// Command/response channel between the LCD sequencer (master) and the bus engine (slave).
interface lcd_bus_engine_if #(
    parameter int DELAY_W = 21
);
    logic               cmd_valid;
    logic               cmd_ready;
    logic [7:0]         cmd_data;
    logic               cmd_rs;
    logic               cmd_read;
    logic               cmd_poll;
    logic [DELAY_W-1:0] cmd_delay;
    logic               done;
    logic [7:0]         rsp_data;
    logic               rsp_timeout;

    modport master (
        output cmd_valid, cmd_data, cmd_rs, cmd_read, cmd_poll, cmd_delay,
        input  cmd_ready, done, rsp_data, rsp_timeout
    );

    modport slave (
        input  cmd_valid, cmd_data, cmd_rs, cmd_read, cmd_poll, cmd_delay,
        output cmd_ready, done, rsp_data, rsp_timeout
    );
endinterface

// File: rtl/lcd_cycle_timer.sv
// Down-counter shared by the bus phases and the post-command delay.
// Loaded on state entry; terminal is high during the last cycle of the loaded span.
module lcd_cycle_timer #(
    parameter int W = 21
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic         terminal
);
    logic [W-1:0] count_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= value;
        end else if (count_q != '0) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign terminal = (count_q[W-1:1] == '0);

endmodule

// File: rtl/lcd_bus_engine.sv
// HD44780-style LCD bus engine: one byte-level command per handshake, 4- or 8-bit bus,
// read capture, busy-flag polling with timeout and a per-command post-transfer delay.
module lcd_bus_engine
    import lcd_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int BUS_WIDTH   = 4,
    parameter int SETUP_US    = 1,
    parameter int E_HIGH_US   = 3,
    parameter int HOLD_US     = 1,
    parameter int DELAY_W     = 21,
    parameter int POLL_MAX    = 255
) (
    input  logic                 CLK,
    input  logic                 RST,
    lcd_bus_engine_if.slave      bus,
    inout  wire  [BUS_WIDTH-1:0] LCD_D,
    output logic                 LCD_RS,
    output logic                 LCD_RW,
    output logic                 LCD_E
);
    localparam logic [DELAY_W-1:0] S_LD = DELAY_W'(us_to_cycles(64'(CLK_FREQ_HZ), 32'(SETUP_US)));
    localparam logic [DELAY_W-1:0] E_LD = DELAY_W'(us_to_cycles(64'(CLK_FREQ_HZ), 32'(E_HIGH_US)));
    localparam logic [DELAY_W-1:0] H_LD = DELAY_W'(us_to_cycles(64'(CLK_FREQ_HZ), 32'(HOLD_US)));
    localparam int PCW = $clog2(POLL_MAX + 1);

    lcd_state_t           state_q, state_d;
    lcd_cmd_t             cmd_q;
    logic                 nib_q;
    logic [PCW-1:0]       poll_cnt_q;
    logic [7:0]           cap_q;
    logic [7:0]           rsp_data_q;
    logic                 rsp_timeout_q;
    logic                 tmr_load;
    logic [DELAY_W-1:0]   tmr_val;
    logic                 tmr_term;
    logic                 active;
    logic                 first_nib;
    logic                 poll_again;
    logic [7:0]           bus_in;
    logic [BUS_WIDTH-1:0] bus_out;
    logic [BUS_WIDTH-1:0] d_drv;

    lcd_cycle_timer #(.W(DELAY_W)) u_timer (
        .CLK      (CLK),
        .RST      (RST),
        .load     (tmr_load),
        .value    (tmr_val),
        .terminal (tmr_term)
    );

    // In 4-bit mode the pins are replicated so either nibble slot can be captured directly.
    if (BUS_WIDTH == 8) begin : g_bus8
        assign bus_in  = LCD_D;
        assign bus_out = cmd_q.data;
    end else begin : g_bus4
        assign bus_in  = {LCD_D, LCD_D};
        assign bus_out = nib_q ? cmd_q.data[3:0] : cmd_q.data[7:4];
    end

    always_comb begin
        active     = (state_q == ST_SETUP) || (state_q == ST_E_HIGH) || (state_q == ST_HOLD);
        first_nib  = (BUS_WIDTH == 4) && !nib_q;
        poll_again = cmd_q.poll && cap_q[7] && ((32'(poll_cnt_q) + 32'd1) < 32'(POLL_MAX));
        state_d    = state_q;
        tmr_load   = 1'b0;
        tmr_val    = S_LD;
        case (state_q)
            ST_IDLE: begin
                if (bus.cmd_valid) begin
                    state_d  = ST_SETUP;
                    tmr_load = 1'b1;
                end
            end
            ST_SETUP: begin
                if (tmr_term) begin
                    state_d  = ST_E_HIGH;
                    tmr_load = 1'b1;
                    tmr_val  = E_LD;
                end
            end
            ST_E_HIGH: begin
                if (tmr_term) begin
                    state_d  = ST_HOLD;
                    tmr_load = 1'b1;
                    tmr_val  = H_LD;
                end
            end
            ST_HOLD: begin
                if (tmr_term) begin
                    if (first_nib || poll_again) begin
                        state_d  = ST_SETUP;
                        tmr_load = 1'b1;
                    end else if (cmd_q.delay == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d  = ST_DELAY;
                        tmr_load = 1'b1;
                        tmr_val  = cmd_q.delay[DELAY_W-1:0];
                    end
                end
            end
            ST_DELAY: begin
                if (tmr_term) state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q       <= ST_IDLE;
            nib_q         <= 1'b0;
            poll_cnt_q    <= '0;
            rsp_data_q    <= '0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_IDLE && bus.cmd_valid) begin
                cmd_q.data  <= bus.cmd_data;
                cmd_q.rs    <= bus.cmd_rs & ~bus.cmd_poll;
                cmd_q.read  <= bus.cmd_read | bus.cmd_poll;
                cmd_q.poll  <= bus.cmd_poll;
                cmd_q.delay <= LCD_DELAY_MAX_W'(bus.cmd_delay);
                nib_q       <= 1'b0;
                poll_cnt_q  <= '0;
                cap_q       <= '0;
            end
            if (state_q == ST_E_HIGH && tmr_term && cmd_q.read) begin
                if (BUS_WIDTH == 8) cap_q <= bus_in;
                else if (nib_q) cap_q[3:0] <= bus_in[3:0];
                else cap_q[7:4] <= bus_in[7:4];
            end
            if (state_q == ST_HOLD && tmr_term) begin
                if (first_nib) begin
                    nib_q <= 1'b1;
                end else begin
                    nib_q <= 1'b0;
                    if (cmd_q.poll) poll_cnt_q <= poll_cnt_q + 1'b1;
                end
            end
            // A poll that ends with bit7 still set has run out of reads.
            if (state_d == ST_DONE && state_q != ST_DONE) begin
                rsp_data_q    <= cap_q;
                rsp_timeout_q <= cmd_q.poll & cap_q[7];
            end
        end
    end

    assign bus.cmd_ready   = (state_q == ST_IDLE);
    assign bus.done        = (state_q == ST_DONE);
    assign bus.rsp_data    = rsp_data_q;
    assign bus.rsp_timeout = rsp_timeout_q;
    assign LCD_E           = (state_q == ST_E_HIGH);
    assign LCD_RW          = active & cmd_q.read;
    assign LCD_RS          = active & cmd_q.rs;
    assign d_drv           = (active && !cmd_q.read) ? bus_out : '0;
    assign LCD_D           = (state_q == ST_IDLE || !cmd_q.read) ? d_drv : {BUS_WIDTH{1'bz}};

endmodule

// File: tb/tb_lcd_bus_engine.sv
// Randomised self-checking bench for lcd_bus_engine: one 8-bit and one 4-bit instance at 4 MHz
// (S=4, E=12, H=4), compared against a timeline model derived from the transfer rules.
module tb_lcd_bus_engine;

    localparam int FREQ  = 4_000_000;
    localparam int PHASE = 20;

    logic       CLK;
    logic       RST;
    int         sel;
    int         errors;
    int         checks;

    logic       c_valid;
    logic [7:0] c_data;
    logic       c_rs, c_read, c_poll;
    logic [20:0] c_delay;

    logic       drv_en;
    logic [7:0] drv_val;
    logic [7:0] resp [0:7];

    wire  [7:0] d8;
    wire  [3:0] d4;
    logic       rs8, rw8, e8, rs4, rw4, e4;

    logic       s_done, s_ready, s_e, s_rw, s_rs, s_to;
    logic [7:0] s_rsp, s_d;

    lcd_bus_engine_if #(.DELAY_W(21)) if8 ();
    lcd_bus_engine_if #(.DELAY_W(21)) if4 ();

    assign if8.cmd_valid = c_valid && (sel == 0);
    assign if8.cmd_data  = c_data;
    assign if8.cmd_rs    = c_rs;
    assign if8.cmd_read  = c_read;
    assign if8.cmd_poll  = c_poll;
    assign if8.cmd_delay = c_delay;
    assign if4.cmd_valid = c_valid && (sel == 1);
    assign if4.cmd_data  = c_data;
    assign if4.cmd_rs    = c_rs;
    assign if4.cmd_read  = c_read;
    assign if4.cmd_poll  = c_poll;
    assign if4.cmd_delay = c_delay;

    assign d8 = (drv_en && sel == 0) ? drv_val : 8'bz;
    assign d4 = (drv_en && sel == 1) ? drv_val[3:0] : 4'bz;

    lcd_bus_engine #(
        .CLK_FREQ_HZ(FREQ), .BUS_WIDTH(8), .SETUP_US(1), .E_HIGH_US(3),
        .HOLD_US(1), .DELAY_W(21), .POLL_MAX(8)
    ) u_dut8 (
        .CLK(CLK), .RST(RST), .bus(if8), .LCD_D(d8), .LCD_RS(rs8), .LCD_RW(rw8), .LCD_E(e8)
    );

    lcd_bus_engine #(
        .CLK_FREQ_HZ(FREQ), .BUS_WIDTH(4), .SETUP_US(1), .E_HIGH_US(3),
        .HOLD_US(1), .DELAY_W(21), .POLL_MAX(3)
    ) u_dut4 (
        .CLK(CLK), .RST(RST), .bus(if4), .LCD_D(d4), .LCD_RS(rs4), .LCD_RW(rw4), .LCD_E(e4)
    );

    always_comb begin
        if (sel == 0) begin
            s_done = if8.done; s_ready = if8.cmd_ready; s_rsp = if8.rsp_data; s_to = if8.rsp_timeout;
            s_e = e8; s_rw = rw8; s_rs = rs8; s_d = d8;
        end else begin
            s_done = if4.done; s_ready = if4.cmd_ready; s_rsp = if4.rsp_data; s_to = if4.rsp_timeout;
            s_e = e4; s_rw = rw4; s_rs = rs4; s_d = {4'h0, d4};
        end
    end

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h (sel=%0d t=%0t)", tag, got, exp, sel, $time);
        end
    endtask

    // Issue one command on the selected instance and follow it cycle by cycle.
    task automatic do_cmd(input logic [7:0] data, input logic rs, input logic rd, input logic poll,
                          input int dly);
        int pmax, nrd, k, tot, done_exp, done_got, pin_bad, t, o, bidx;
        logic bw4, rd_eff, rs_eff, exp_to, e_x, got_to;
        logic [7:0] exp_rsp, d_x, b, got_rsp;
        logic bad;
        #1;
        bw4    = (sel == 1);
        pmax   = bw4 ? 3 : 8;
        rd_eff = rd | poll;
        rs_eff = rs & ~poll;
        nrd    = 1;
        exp_to = 1'b0;
        if (poll) begin
            exp_to = 1'b1;
            for (int i = 0; i < pmax; i++) begin
                nrd = i + 1;
                if (!resp[i][7]) begin
                    exp_to = 1'b0;
                    break;
                end
            end
        end
        exp_rsp  = resp[nrd-1];
        k        = nrd * (bw4 ? 2 : 1);
        tot      = k * PHASE;
        done_exp = tot + dly + 1;

        chk("ready_idle", 32'(s_ready), 32'd1);
        c_valid = 1'b1; c_data = data; c_rs = rs; c_read = rd; c_poll = poll; c_delay = 21'(dly);
        @(posedge CLK); #1;
        c_valid = 1'b0; c_data = 8'($urandom); c_rs = 1'($urandom); c_read = 1'($urandom);
        c_poll = 1'($urandom); c_delay = 21'($urandom);

        done_got = -1; pin_bad = 0; got_rsp = 8'h00; got_to = 1'b0;
        for (int c = 1; c <= done_exp + 4 && done_got < 0; c++) begin
            t = (c - 1) / PHASE;
            o = (c - 1) % PHASE;
            if (rd_eff && c <= tot) begin
                bidx    = bw4 ? t / 2 : t;
                b       = resp[bidx];
                drv_en  = 1'b1;
                drv_val = bw4 ? {4'h0, ((t % 2 == 0) ? b[7:4] : b[3:0])} : b;
            end else begin
                drv_en = 1'b0;
            end
            @(negedge CLK);
            if (c <= tot) begin
                e_x = (o >= 4 && o < 16);
                if (rd_eff) d_x = drv_val;
                else if (bw4) d_x = {4'h0, ((t % 2 == 0) ? data[7:4] : data[3:0])};
                else d_x = data;
                bad = (s_e !== e_x) || (s_rw !== rd_eff) || (s_rs !== rs_eff) || (s_d !== d_x);
            end else begin
                bad = (s_e !== 1'b0) || (s_rw !== 1'b0) || (s_rs !== 1'b0) ||
                      (!rd_eff && s_d !== 8'h00);
            end
            bad = bad || (s_done !== (c == done_exp)) || (s_ready !== 1'b0);
            if (bad) pin_bad++;
            if (s_done) begin
                done_got = c;
                got_rsp  = s_rsp;
                got_to   = s_to;
            end
            @(posedge CLK); #1;
        end
        drv_en = 1'b0;
        chk("done_cycle", 32'(done_got), 32'(done_exp));
        chk("bus_pins", 32'(pin_bad), 32'd0);
        if (rd_eff) chk("rsp_data", 32'(got_rsp), 32'(exp_rsp));
        chk("rsp_timeout", 32'(got_to), 32'(exp_to));
        if (done_got < 0) begin
            RST = 1'b1;
            @(posedge CLK); #1;
            RST = 1'b0;
            @(negedge CLK);
        end else begin
            @(negedge CLK);
            chk("ready_after_done", 32'(s_ready), 32'd1);
        end
    endtask

    initial begin
        int accepts, acc1, acc2, ndone, kind;
        errors = 0; checks = 0;
        RST = 1'b1; sel = 0; drv_en = 1'b0; drv_val = 8'h00;
        c_valid = 1'b0; c_data = 8'h00; c_rs = 1'b0; c_read = 1'b0; c_poll = 1'b0; c_delay = '0;
        for (int i = 0; i < 8; i++) resp[i] = 8'h00;
        repeat (3) @(posedge CLK);
        #1 RST = 1'b0;
        @(negedge CLK);
        for (int w = 0; w < 2; w++) begin
            sel = w; #1;
            chk("rst_ready", 32'(s_ready), 32'd1);
            chk("rst_done", 32'(s_done), 32'd0);
            chk("rst_rsp", 32'(s_rsp), 32'd0);
            chk("rst_timeout", 32'(s_to), 32'd0);
            chk("rst_pins", {28'd0, s_e, s_rw, s_rs, 1'b0}, 32'd0);
            chk("rst_lcd_d", 32'(s_d), 32'd0);
        end

        sel = 0; do_cmd(8'h38, 1'b0, 1'b0, 1'b0, 10);
        sel = 1; do_cmd(8'h28, 1'b1, 1'b0, 1'b0, 0);
        sel = 1; resp[0] = 8'hA5; do_cmd(8'h00, 1'b0, 1'b1, 1'b0, 3);
        sel = 0; resp[0] = 8'h80; resp[1] = 8'h80; resp[2] = 8'h03;
        do_cmd(8'h00, 1'b0, 1'b0, 1'b1, 0);
        sel = 1; for (int i = 0; i < 8; i++) resp[i] = 8'h80;
        do_cmd(8'h00, 1'b1, 1'b0, 1'b1, 2);
        sel = 0; do_cmd(8'hFF, 1'b1, 1'b0, 1'b1, 1);
        sel = 0; do_cmd(8'hC3, 1'b1, 1'b0, 1'b0, 500);

        // Reset in the middle of E_HIGH after a read left rsp_data non-zero.
        sel = 0; resp[0] = 8'h5A; do_cmd(8'h00, 1'b0, 1'b1, 1'b0, 2);
        #1;
        c_valid = 1'b1; c_data = 8'h38; c_rs = 1'b1; c_read = 1'b0; c_poll = 1'b0; c_delay = 21'd5;
        @(posedge CLK); #1;
        c_valid = 1'b0;
        repeat (9) @(posedge CLK);
        @(negedge CLK);
        chk("rst_mid_e_before", 32'(s_e), 32'd1);
        RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
        @(negedge CLK);
        chk("rst_mid_e", 32'(s_e), 32'd0);
        chk("rst_mid_ready", 32'(s_ready), 32'd1);
        chk("rst_mid_rsp", 32'(s_rsp), 32'd0);
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            if (s_done) ndone++;
            @(negedge CLK);
        end
        chk("rst_mid_no_done", 32'(ndone), 32'd0);

        // cmd_valid held high: second acceptance exactly one cycle after the first done.
        sel = 0; #1;
        c_valid = 1'b1; c_data = 8'h11; c_rs = 1'b0; c_read = 1'b0; c_poll = 1'b0; c_delay = '0;
        accepts = 0; acc1 = -1; acc2 = -1;
        for (int cyc = 0; cyc < 44; cyc++) begin
            if (cyc > 0) @(negedge CLK);
            if (s_ready && c_valid) begin
                accepts++;
                if (acc1 < 0) acc1 = cyc;
                else if (acc2 < 0) acc2 = cyc;
            end
            if (cyc == 43) c_valid = 1'b0;
            @(posedge CLK);
        end
        @(negedge CLK);
        chk("hold_valid_first", 32'(acc1), 32'd0);
        chk("hold_valid_second", 32'(acc2), 32'd22);
        chk("hold_valid_count", 32'(accepts), 32'd2);

        for (int n = 0; n < 40; n++) begin
            sel  = n % 2;
            kind = $urandom_range(0, 2);
            for (int i = 0; i < 8; i++)
                resp[i] = (kind == 2) ? {($urandom_range(0, 9) < 7), 7'($urandom)} : 8'($urandom);
            do_cmd(8'($urandom), 1'($urandom), kind == 1, kind == 2, $urandom_range(0, 12));
            repeat ($urandom_range(0, 3)) @(negedge CLK);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
